// File: rtl/ysyx22041405_ex_ctrl_pkg.sv
// Shared EX-stage definitions: ID_EX message geometry and the EX slot state encoding.
`ifndef YSYX22041405_EX_CTRL_PKG_SV
`define YSYX22041405_EX_CTRL_PKG_SV

`ifndef ID_EX_WIDTH
`define ID_EX_WIDTH 256
`endif
// Bit positions of the ebreak / multi-cycle flags inside the ID_EX message
`ifndef ID_EX_EBREAK_BIT
`define ID_EX_EBREAK_BIT 0
`endif
`ifndef ID_EX_MDU_BIT
`define ID_EX_MDU_BIT 1
`endif

package ysyx22041405_ex_ctrl_pkg;

    typedef enum logic [1:0] {
        EX_S_EMPTY  = 2'd0,  // slot free
        EX_S_MSTART = 2'd1,  // MDU op latched, start pulse out
        EX_S_MWAIT  = 2'd2,  // MDU iterating
        EX_S_VALID  = 2'd3   // finished op waiting for the LSU
    } ex_state_e;

endpackage

`endif

// File: rtl/ysyx22041405_ex_fsm.sv
// EX slot sequencer: state register, next-state and valid/ready handshake decode.
module ysyx22041405_ex_fsm
    import ysyx22041405_ex_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic id_valid,
    input  logic id_is_mdu,
    input  logic flush,
    input  logic ls_ready,
    input  logic mdu_done,
    output logic id_ready,
    output logic accept,
    output logic handoff,
    output logic mdu_cap,
    output logic in_mdu,
    output logic mdu_kill,
    output logic mdu_start,
    output logic ex_valid
);

    ex_state_e state;
    ex_state_e state_nxt;

    assign in_mdu   = (state == EX_S_MSTART) | (state == EX_S_MWAIT);
    assign id_ready = (state == EX_S_EMPTY) | ((state == EX_S_VALID) & ls_ready);
    assign accept   = id_valid & id_ready & ~flush;
    assign handoff  = ex_valid & ls_ready;
    // A done pulse only counts while the MDU is actually iterating
    assign mdu_cap  = (state == EX_S_MWAIT) & mdu_done & ~flush;
    assign mdu_kill = flush & in_mdu;

    // Next state; flush overrides accept, handoff and done
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EX_S_EMPTY;
        end else begin
            case (state)
                EX_S_EMPTY: begin
                    if (accept) state_nxt = id_is_mdu ? EX_S_MSTART : EX_S_VALID;
                end
                EX_S_MSTART: state_nxt = EX_S_MWAIT;
                EX_S_MWAIT: begin
                    if (mdu_done) state_nxt = EX_S_VALID;
                end
                EX_S_VALID: begin
                    if (accept)       state_nxt = id_is_mdu ? EX_S_MSTART : EX_S_VALID;
                    else if (ls_ready) state_nxt = EX_S_EMPTY;
                end
                default: state_nxt = EX_S_EMPTY;
            endcase
        end
    end

    // State register with registered state decodes
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EX_S_EMPTY;
            ex_valid  <= 1'b0;
            mdu_start <= 1'b0;
        end else begin
            state     <= state_nxt;
            ex_valid  <= (state_nxt == EX_S_VALID);
            mdu_start <= (state_nxt == EX_S_MSTART);
        end
    end

endmodule

// File: rtl/ysyx22041405_ex_ctrl.sv
// EX-stage controller: ID->EX pipeline register, MDU result capture and stall counter.
module ysyx22041405_ex_ctrl
    import ysyx22041405_ex_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int MSG_W = `ID_EX_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [MSG_W-1:0] id_msg,
    input  logic             id_is_mdu,
    input  logic             id_ebreak,
    output logic             id_ready,
    input  logic             flush,
    output logic [MSG_W-1:0] ex_msg,
    output logic             ex_valid,
    output logic             ex_mdu_sel,
    output logic [WIDTH-1:0] mdu_res_q,
    input  logic             ls_ready,
    output logic             mdu_start,
    output logic             mdu_kill,
    input  logic             mdu_done,
    input  logic [WIDTH-1:0] mdu_result,
    output logic             ebreak_o,
    output logic [31:0]      mdu_stall_cnt
);

    logic accept;
    logic handoff;
    logic mdu_cap;
    logic in_mdu;
    logic ebreak_q;

    ysyx22041405_ex_fsm u_fsm (
        .clk       (clk),
        .rst       (rst),
        .id_valid  (id_valid),
        .id_is_mdu (id_is_mdu),
        .flush     (flush),
        .ls_ready  (ls_ready),
        .mdu_done  (mdu_done),
        .id_ready  (id_ready),
        .accept    (accept),
        .handoff   (handoff),
        .mdu_cap   (mdu_cap),
        .in_mdu    (in_mdu),
        .mdu_kill  (mdu_kill),
        .mdu_start (mdu_start),
        .ex_valid  (ex_valid)
    );

    // Ebreak only reported on a real handoff; a redirect in that cycle swallows it
    assign ebreak_o = handoff & ebreak_q & ~flush;

    // Payload only moves on accept, so it is stable while the slot is occupied
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_msg     <= '0;
            ex_mdu_sel <= 1'b0;
            ebreak_q   <= 1'b0;
        end else if (accept) begin
            ex_msg     <= id_msg;
            ex_mdu_sel <= id_is_mdu;
            ebreak_q   <= id_ebreak;
        end
    end

    // MDU result capture on the done pulse seen in MDU_WAIT
    always_ff @(posedge clk) begin
        if (rst)          mdu_res_q <= '0;
        else if (mdu_cap) mdu_res_q <= mdu_result;
    end

    // Stall counter: every cycle in MDU_START/MDU_WAIT, wraps, survives flush
    always_ff @(posedge clk) begin
        if (rst)         mdu_stall_cnt <= '0;
        else if (in_mdu) mdu_stall_cnt <= mdu_stall_cnt + 32'd1;
    end

endmodule
